// File: rtl/bram_fifo_s9_pkg.sv
// rtl/bram_fifo_s9_pkg.sv - shared widths and constants for the block-RAM byte FIFO
package bram_fifo_s9_pkg;
  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;
  localparam int OQ_DEPTH   = 3;
  localparam int OQ_CNT_W   = 2;
  localparam int LEVEL_W    = 12;
endpackage

// File: rtl/bram_fifo_s9_if.sv
// rtl/bram_fifo_s9_if.sv - upstream/downstream ready-valid byte streams of the FIFO
interface bram_fifo_s9_if import bram_fifo_s9_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/bram_fifo_oq.sv
// rtl/bram_fifo_oq.sv - 3-entry output queue absorbing RAM read data; head at mem[0]
module bram_fifo_oq import bram_fifo_s9_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  output logic [DATA_W-1:0]   head,
  output logic [OQ_CNT_W-1:0] count
);
  logic [DATA_W-1:0]   mem [OQ_DEPTH];
  logic                pop_ok;
  logic [OQ_CNT_W-1:0] widx;

  assign pop_ok = pop & (count != '0);
  // a same-cycle pop shifts the queue, so the push lands one slot lower
  assign widx   = count - OQ_CNT_W'(pop_ok);
  assign head   = mem[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count + OQ_CNT_W'(push) - OQ_CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (pop_ok) begin
      for (int i = 0; i < OQ_DEPTH - 1; i++) begin
        mem[i] <= mem[i+1];
      end
    end
    if (push && (widx < OQ_CNT_W'(OQ_DEPTH))) begin
      mem[widx] <= push_data;
    end
  end
endmodule

// File: rtl/bram_fifo_s9.sv
// rtl/bram_fifo_s9.sv - byte FIFO controller over an external dual-port BRAM; BRAM_FIFO_LEVEL_EN adds the level output
module bram_fifo_s9 import bram_fifo_s9_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  bram_fifo_s9_if.slave     s,
  output logic              ram_wea,
  output logic              ram_ena,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dia,
  output logic              ram_web,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [DATA_W-1:0] ram_dib,
  output logic              ram_ssra,
  output logic              ram_ssrb,
  output logic              ram_dipa,
  output logic              ram_dipb,
  input  logic [DATA_W-1:0] ram_dob
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [LEVEL_W-1:0] level
`endif
);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   rptr;
  logic [ADDR_W:0]     ram_count;
  logic                rd_pend;
  logic [OQ_CNT_W-1:0] oq_count;
  logic [2:0]          inflight;
  logic                wr;
  logic                rd_issue;
  logic [DATA_W-1:0]   oq_head;

  assign s.in_ready = (ram_count != FULL);
  assign wr         = s.in_valid & s.in_ready;
  // reads in flight plus queued bytes may never exceed the queue depth
  assign inflight   = 3'(oq_count) + 3'(rd_pend);
  assign rd_issue   = (ram_count != '0) && (inflight < 3'(OQ_DEPTH));

  assign ram_ena   = wr;
  assign ram_wea   = wr;
  assign ram_addra = wptr;
  assign ram_dia   = s.in_data;
  assign ram_enb   = rd_issue;
  assign ram_addrb = rptr;
  assign ram_web   = 1'b0;
  assign ram_dib   = '0;
  assign ram_ssra  = 1'b0;
  assign ram_ssrb  = 1'b0;
  assign ram_dipa  = 1'b0;
  assign ram_dipb  = 1'b0;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      rd_pend   <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (rd_issue) begin
        rptr <= rptr + ADDR_W'(1);
      end
      rd_pend <= rd_issue;
      case ({wr, rd_issue})
        2'b10:   ram_count <= ram_count + (ADDR_W+1)'(1);
        2'b01:   ram_count <= ram_count - (ADDR_W+1)'(1);
        default: ram_count <= ram_count;
      endcase
    end
  end

  bram_fifo_oq #(.DATA_W(DATA_W)) u_oq (
    .clk       (CLK),
    .rst       (reset),
    .push      (rd_pend),
    .push_data (ram_dob),
    .pop       (s.out_valid & s.out_ready),
    .head      (oq_head),
    .count     (oq_count)
  );

  assign s.out_valid = (oq_count != '0);
  assign s.out_data  = oq_head;

`ifdef BRAM_FIFO_LEVEL_EN
  assign level = LEVEL_W'(ram_count) + LEVEL_W'(rd_pend) + LEVEL_W'(oq_count);
`endif
endmodule

// File: tb/tb_bram_fifo_s9.sv
// tb/tb_bram_fifo_s9.sv - directed and random checks of bram_fifo_s9 against a behavioural BRAM and scoreboard
module tb_bram_fifo_s9;
  import bram_fifo_s9_pkg::*;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        ram_wea, ram_ena, ram_web, ram_enb;
  logic [10:0] ram_addra, ram_addrb;
  logic [7:0]  ram_dia, ram_dib, ram_dob;
  logic        ram_ssra, ram_ssrb, ram_dipa, ram_dipb;
  logic [LEVEL_W-1:0] level;
  logic [7:0]  ram [2048];
  logic [7:0]  sb [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          pops = 0;

  bram_fifo_s9_if bus ();

  bram_fifo_s9 dut (
    .CLK       (CLK),
    .reset     (reset),
    .s         (bus.slave),
    .ram_wea   (ram_wea),
    .ram_ena   (ram_ena),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_web   (ram_web),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dib   (ram_dib),
    .ram_ssra  (ram_ssra),
    .ram_ssrb  (ram_ssrb),
    .ram_dipa  (ram_dipa),
    .ram_dipb  (ram_dipb),
    .ram_dob   (ram_dob)
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

`ifndef BRAM_FIFO_LEVEL_EN
  assign level = '0;
`endif

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_ena && ram_wea) ram[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= ram[ram_addrb];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // handshakes are stable at the falling edge and complete at the next rising edge
  always @(negedge CLK) begin
    if (!reset) begin
      if (ram_wea && ram_enb) check("collide", 32'(ram_addra == ram_addrb), 32'd0);
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("order", 32'(bus.out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic drain(input string tag);
    int k;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (k = 0; k < 2400; k++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lowcnt, gap, k;
    logic got;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // reset state
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_ram_ena", 32'(ram_ena), 32'd0);
    check("rst_ram_enb", 32'(ram_enb), 32'd0);
    check("rst_ram_web", 32'(ram_web), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_enb", 32'(ram_enb), 32'd0);

    // single byte latency
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("lat_enb_n", 32'(ram_enb), 32'd1);
    check("lat_ov_n", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_ov_n1", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_ov_n2", 32'(bus.out_valid), 32'd1);
    check("lat_data", 32'(bus.out_data), 32'h5A);
    tick();
    check("lat_ov_n3", 32'(bus.out_valid), 32'd0);

    // 4096-byte full-rate stream
    pops   = 0;
    lowcnt = 0;
    gap    = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      bus.in_data = 8'(i);
      if (!bus.in_ready) lowcnt++;
      tick();
      if (i >= 2 && !bus.out_valid) gap++;
    end
    drain("stream_drain");
    check("stream_in_ready_low", 32'(lowcnt), 32'd0);
    check("stream_gaps", 32'(gap), 32'd0);
    check("stream_pops", 32'(pops), 32'd4096);

    // fill to capacity with the sink stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    for (k = 0; k < 2100; k++) begin
      bus.in_data = 8'(n ^ 8'hA5);
      if (bus.in_ready) n++;
      tick();
    end
    check("fill_accepted", 32'(n), 32'd2051);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("fill_level", 32'(level), 32'd2051);
`endif
    bus.in_data   = 8'h3C;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    got = 1'b0;
    for (k = 0; k < 3; k++) begin
      if (bus.in_ready) begin
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    check("refill_accept", 32'(got), 32'd1);
    check("refill_full_again", 32'(bus.in_ready), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("refill_level", 32'(level), 32'd2051);
`endif
    drain("fill_drain");

    // random valid/ready traffic
    n = 0;
    for (k = 0; k < 60000 && n < 20000; k++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid && bus.in_ready) n++;
      tick();
    end
    check("rand_accepted", 32'(n), 32'd20000);
    drain("rand_drain");

    // asynchronous reset with two bytes queued
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    tick();
    bus.in_data   = 8'h22;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    tick();
    check("pre_rst_ov", 32'(bus.out_valid), 32'd1);
`ifdef BRAM_FIFO_LEVEL_EN
    check("pre_rst_level", 32'(level), 32'd2);
`endif
    reset = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_ena", 32'(ram_ena), 32'd0);
    check("mid_rst_enb", 32'(ram_enb), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
    check("mid_rst_level", 32'(level), 32'd0);
`endif
    tick();
    reset = 1'b0;
    tick();
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC3;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    got = 1'b0;
    for (k = 0; k < 6; k++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("post_rst_seen", 32'(got), 32'd1);
    check("post_rst_first", 32'(bus.out_data), 32'hC3);
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
